// File: rtl/riio_eg1d80v_supply_seq.sv
// rtl/riio_eg1d80v_supply_seq.sv - EG1D80V IO-ring supply power sequencer
module riio_eg1d80v_supply_seq #(
    parameter int N_DOM = 4,
    parameter int CNT_W = 16,
    parameter int DOM_W = $clog2(N_DOM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_req,
    input  logic             clr_fault,
    input  logic [CNT_W-1:0] ramp_dly,
    input  logic [CNT_W-1:0] pg_timeout,
    input  logic [N_DOM-1:0] pg_i,
    output logic [N_DOM-1:0] en_o,
    output logic             iso_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             fault_o,
    output logic [DOM_W-1:0] fault_dom_o
);

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_EN,
        S_UP_SET,
        S_ON,
        S_DN_ISO,
        S_DN_DIS,
        S_FAULT
    } state_t;

    localparam logic [DOM_W-1:0] LAST_IDX = DOM_W'(N_DOM - 1);

    logic [N_DOM-1:0] pg_meta_q;
    logic [N_DOM-1:0] pg_s_q;

    state_t           state_q, state_d;
    logic [DOM_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DOM-1:0] en_q, en_d;
    logic             iso_q, iso_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic [DOM_W-1:0] fdom_q, fdom_d;

    logic [N_DOM-1:0] pg_lost;
    logic [DOM_W-1:0] lost_idx;
    logic             enter;

    // Two-flop synchroniser on the asynchronous power-good inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pg_meta_q <= '0;
            pg_s_q    <= '0;
        end else begin
            pg_meta_q <= pg_i;
            pg_s_q    <= pg_meta_q;
        end
    end

    // Lowest-numbered enabled domain whose power-good has dropped
    always_comb begin
        pg_lost  = en_q & ~pg_s_q;
        lost_idx = '0;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (pg_lost[i]) begin
                lost_idx = DOM_W'(i);
            end
        end
    end

    // Next-state, domain index and enable vector; 'enter' marks any state entry
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        fdom_d  = fdom_q;
        enter   = 1'b0;
        case (state_q)
            S_OFF: begin
                en_d = '0;
                if (pwr_req) begin
                    state_d  = S_UP_EN;
                    idx_d    = '0;
                    en_d[0]  = 1'b1;
                    enter    = 1'b1;
                end
            end
            S_UP_EN: begin
                // Abort wins, then power-good, then timeout
                if (!pwr_req) begin
                    state_d      = S_DN_DIS;
                    en_d[idx_q]  = 1'b0;
                    enter        = 1'b1;
                end else if (pg_s_q[idx_q]) begin
                    state_d = S_UP_SET;
                    enter   = 1'b1;
                end else if (pg_timeout != '0 && cnt_q == pg_timeout) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    fdom_d  = idx_q;
                    enter   = 1'b1;
                end
            end
            S_UP_SET: begin
                if (!pwr_req) begin
                    state_d      = S_DN_DIS;
                    en_d[idx_q]  = 1'b0;
                    enter        = 1'b1;
                end else if (cnt_q == ramp_dly) begin
                    enter = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_ON;
                    end else begin
                        state_d     = S_UP_EN;
                        idx_d       = idx_q + 1'b1;
                        en_d[idx_d] = 1'b1;
                    end
                end
            end
            S_ON: begin
                // A lost supply outranks a power-down request
                if (|pg_lost) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    fdom_d  = lost_idx;
                    enter   = 1'b1;
                end else if (!pwr_req) begin
                    state_d = S_DN_ISO;
                    enter   = 1'b1;
                end
            end
            S_DN_ISO: begin
                state_d        = S_DN_DIS;
                idx_d          = LAST_IDX;
                en_d[LAST_IDX] = 1'b0;
                enter          = 1'b1;
            end
            S_DN_DIS: begin
                if (cnt_q == ramp_dly) begin
                    enter = 1'b1;
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d       = idx_q - 1'b1;
                        en_d[idx_d] = 1'b0;
                    end
                end
            end
            S_FAULT: begin
                en_d = '0;
                if (clr_fault && !pwr_req) begin
                    state_d = S_OFF;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_d = S_OFF;
                en_d    = '0;
                enter   = 1'b1;
            end
        endcase
    end

    // Saturating in-state counter and outputs decoded from the next state
    always_comb begin
        if (enter) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        iso_d   = (state_d != S_ON);
        ready_d = (state_d == S_ON);
        busy_d  = (state_d != S_OFF) && (state_d != S_ON) && (state_d != S_FAULT);
        fault_d = (state_d == S_FAULT);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            iso_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            fdom_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            iso_q   <= iso_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            fdom_q  <= fdom_d;
        end
    end

    assign en_o        = en_q;
    assign iso_o       = iso_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault_q;
    assign fault_dom_o = fdom_q;

endmodule

// File: doc/riio_eg1d80v_supply_seq.md
# riio_eg1d80v_supply_seq

Parametrised power-sequencing controller for the EG1D80V 1.8 V IO ring. It drives the enables of N_DOM pad/core supply domains in a fixed order, waits for each domain's power-good, and applies a programmable settle delay. It also controls core-to-IO isolation and latches the first domain that faults. It sits between the chip power manager (request/ready) and the supply-cell enable/monitor pins of the IO ring.

## Interface
- N_DOM, 4, number of supply domains sequenced (≥2); domain 0 powers first, last off
- CNT_W, 16, width of delay/timeout counters and their config inputs
- DOM_W, $clog2(N_DOM), width of domain index outputs
- clk  in  1  sequencer clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- pwr_req  in  1  level: 1 = power domains up, 0 = power down
- clr_fault  in  1  single-cycle pulse, clears FAULT (accepted only while pwr_req=0)
- ramp_dly  in  CNT_W  settle cycles after power-good (up) / after disable (down)
- pg_timeout  in  CNT_W  max cycles to wait for power-good; 0 = timeout disabled
- pg_i  in  N_DOM  asynchronous power-good per domain, from supply monitors
- en_o  out  N_DOM  domain supply enable, registered
- iso_o  out  1  isolation clamp, 1 = isolated, registered
- ready_o  out  1  all domains up and isolation released
- busy_o  out  1  sequence in progress (any state except OFF, ON, FAULT)
- fault_o  out  1  sticky fault flag
- fault_dom_o  out  DOM_W  index of domain that caused the fault

## Operation
- pg_i passes through a 2-flop synchroniser per bit (pg_s); the FSM uses only pg_s.
- Index register idx (DOM_W) and counter cnt (CNT_W, saturating); cnt clears on every state entry and increments once per cycle in state.
- States: OFF, UP_EN, UP_SET, ON, DN_ISO, DN_DIS, FAULT.
- OFF: en_o=0, iso_o=1. pwr_req=1 -> UP_EN, idx=0.
- UP_EN: en_o[idx]=1. pg_s[idx]=1 -> UP_SET. Else if pg_timeout≠0 and cnt==pg_timeout -> FAULT with fault_dom_o=idx.
- UP_SET: exit when cnt==ramp_dly (0 = one cycle in state). If idx==N_DOM-1 -> ON; else idx+1 -> UP_EN.
- ON: iso_o=0, ready_o=1. pwr_req=0 -> DN_ISO. Any enabled pg_s bit low -> FAULT with fault_dom_o = lowest such index; fault takes priority over pwr_req=0.
- DN_ISO: iso_o=1, ready_o=0. Exactly one cycle, then DN_DIS with idx=N_DOM-1.
- DN_DIS: en_o[idx]=0 on entry. Exit when cnt==ramp_dly. If idx==0 -> OFF; else idx-1 -> DN_DIS.
- Abort: pwr_req=0 during UP_EN/UP_SET -> DN_DIS at the current idx. That domain is disabled, then the lower ones descend. No DN_ISO, because isolation is already 1.
- pwr_req=1 during DN_ISO/DN_DIS is ignored until OFF is reached; OFF then restarts normally.
- Timeout applies in UP_EN only. pg_s during UP_SET and DN_* is not checked.
- FAULT: en_o=0 (all, same cycle as entry), iso_o=1, fault_o=1, fault_dom_o held. Exit to OFF only on clr_fault=1 with pwr_req=0; fault_o clears on that exit. A second fault cannot overwrite fault_dom_o.
- Config inputs are sampled every cycle. Changing them mid-sequence affects only the current comparison.

## Timing
- Reset: state=OFF, idx=0, cnt=0, en_o=0, iso_o=1, ready_o=0, busy_o=0, fault_o=0, fault_dom_o=0, pg_s=0.
- All outputs are registered and decoded from next-state, so they change in the cycle the state changes.
- pwr_req=1 sampled at edge k -> en_o[0]=1 and busy_o=1 after edge k.
- pg_i rising before edge p -> pg_s=1 after edge p+1 -> UP_SET after edge p+2.
- UP_SET lasts ramp_dly+1 cycles. The next en_o bit rises on the following edge.
- Total power-up, with pg already high: per domain 3 (sync+detect) + ramp_dly+1 cycles. ready_o rises on the same edge as iso_o falls.
- Power-down: pwr_req=0 -> iso_o=1/ready_o=0 next edge. After 1 cycle en_o[N_DOM-1]=0. Each following domain drops ramp_dly+1 cycles later.
- Timeout: fault_o rises on the edge after cnt==pg_timeout is sampled with pg_s low, i.e. pg_timeout+1 cycles after entering UP_EN.
- rst asserted in any state returns every output to its reset value on the next edge. en_o and iso_o do not sequence down on reset.

## Test plan
- N_DOM=4, ramp_dly=3, pg_i tracking en_o with 2-cycle delay, pwr_req 0->1 -> en_o steps 0001, 0011, 0111, 1111 at fixed spacing; ready_o=1, iso_o=0; busy_o=0 in ON.
- From ON, pwr_req=0 -> iso_o=1 next cycle; en_o steps 0111, 0011, 0001, 0000, each 4 cycles apart; OFF reached.
- pg_timeout=10, pg_i[2] held low -> fault_o=1, fault_dom_o=2, en_o=0000 exactly 11 cycles after en_o[2] rose; clr_fault with pwr_req=1 is ignored, and with pwr_req=0 returns to OFF.
- In ON, drop pg_i[1] for 3 cycles -> FAULT with fault_dom_o=1, en_o=0, iso_o=1; pg_i[1] returning does not clear it.
- pwr_req=0 while in UP_SET of idx=1 -> en_o 0011->0001->0000 with no DN_ISO cycle; re-assert pwr_req mid-down -> completes to OFF, then restarts from domain 0.
- rst pulse mid power-up, then ramp_dly=0 and pg_timeout=0 -> all outputs at reset values after 1 edge; with pg_i stuck low, the sequence waits in UP_EN indefinitely, with no fault.
